// File: rtl/nt_stream_rr_arbiter.sv
// nt_stream_rr_arbiter
// Packet-level round-robin arbiter that merges two AXI4-Stream sources onto
// the single pipeline ingress. A grant is held for a whole packet and is
// released only on the tlast handshake, so packets never interleave.
//
// Handshake: a beat moves on a port in any cycle where its tvalid and tready
// are both high. tvalid never waits on tready. The granted source sees
// m_tready directly on its tready. The other source sees tready = 0.
//
// Optional feature macro: NT_ARB_PKT_CNT_EN adds the per-source packet
// counters pkt_cnt0/pkt_cnt1 and the CNT_W parameter.
module nt_stream_rr_arbiter #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
`ifdef NT_ARB_PKT_CNT_EN
    parameter int CNT_W  = 32,
`endif
    parameter int USER_W = 48
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic [USER_W-1:0] s0_tuser,
    input  logic              s0_tlast,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic [USER_W-1:0] s1_tuser,
    input  logic              s1_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [USER_W-1:0] m_tuser,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
`ifdef NT_ARB_PKT_CNT_EN
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
`endif
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state_q;
    logic   grant_q;
    logic   rr_ptr_q;
    logic   busy;
    logic   last_xfer;

    assign busy      = (state_q == BUSY);
    assign dbg_state = state_q;

    // Datapath mux: the granted source drives m_* while BUSY, all zero otherwise.
    always_comb begin
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tuser   = '0;
        m_tlast   = 1'b0;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        if (busy) begin
            if (grant_q) begin
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tuser   = s1_tuser;
                m_tlast   = s1_tlast;
                m_tvalid  = s1_tvalid;
                s1_tready = m_tready;
            end else begin
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tuser   = s0_tuser;
                m_tlast   = s0_tlast;
                m_tvalid  = s0_tvalid;
                s0_tready = m_tready;
            end
        end
    end

    assign last_xfer = m_tvalid & m_tready & m_tlast;

    // Arbitration FSM: pick a source in IDLE, hold it until its tlast handshake.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s0_tvalid | s1_tvalid) begin
                        // Tie goes to rr_ptr; a lone requester always wins.
                        grant_q <= (s0_tvalid & s1_tvalid) ? rr_ptr_q : s1_tvalid;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_xfer) begin
                        rr_ptr_q <= ~grant_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NT_ARB_PKT_CNT_EN
    // Packet counters: bump the granted source's count on each tlast handshake, wrapping.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (last_xfer) begin
            if (grant_q) pkt_cnt1 <= pkt_cnt1 + 1'b1;
            else         pkt_cnt0 <= pkt_cnt0 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nt_stream_rr_arbiter.sv
// Directed bench for nt_stream_rr_arbiter. Each source is a small packet
// generator whose beat content encodes {source, packet, beat}, so every
// expected m_* value follows from a hand-written per-cycle table of codes.
module tb_nt_stream_rr_arbiter;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int USER_W = 48;
`ifdef NT_ARB_PKT_CNT_EN
  localparam int CNT_W  = 2;
`endif
  localparam logic [7:0] IDLE_CODE = 8'hFF;

  logic              ap_clk;
  logic              ap_rst;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KEEP_W-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [USER_W-1:0] s0_tuser, s1_tuser, m_tuser;
  logic              s0_tlast, s1_tlast, m_tlast;
  logic              s0_tvalid, s1_tvalid, m_tvalid;
  logic              s0_tready, s1_tready, m_tready;
  logic              dbg_state;
`ifdef NT_ARB_PKT_CNT_EN
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  // source generator state
  int left_q[2];
  int beat_q[2];
  int pkt_q[2];
  int len_q[2];

  logic [7:0] exp_q[$];
  bit         rdy_q[$];

  nt_stream_rr_arbiter #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
`ifdef NT_ARB_PKT_CNT_EN
    .CNT_W(CNT_W),
`endif
    .USER_W(USER_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
    .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
    .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
`ifdef NT_ARB_PKT_CNT_EN
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] code_of(input int src, input int pkt, input int beat);
    logic [3:0] s;
    logic [1:0] p;
    logic [1:0] b;
    s = src[3:0];
    p = pkt[1:0];
    b = beat[1:0];
    return {s, p, b};
  endfunction

  function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] c);
    return {64{c}};
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input logic [7:0] c);
    return {8{c}};
  endfunction

  function automatic logic [USER_W-1:0] mk_user(input logic [7:0] c);
    return {40'h0, c ^ 8'h62};
  endfunction

  task automatic load_src(input int n0, input int n1);
    for (int i = 0; i < 2; i++) begin
      beat_q[i] = 0;
      pkt_q[i]  = 0;
      len_q[i]  = 2;
    end
    left_q[0] = n0;
    left_q[1] = n1;
  endtask

  // driver: present each source's current beat
  task automatic drive_src();
    logic [7:0] c0, c1;
    c0 = code_of(0, pkt_q[0], beat_q[0]);
    c1 = code_of(1, pkt_q[1], beat_q[1]);
    s0_tvalid = (left_q[0] > 0);
    s0_tdata  = mk_data(c0);
    s0_tkeep  = mk_keep(c0);
    s0_tuser  = mk_user(c0);
    s0_tlast  = (beat_q[0] == len_q[0] - 1);
    s1_tvalid = (left_q[1] > 0);
    s1_tdata  = mk_data(c1);
    s1_tkeep  = mk_keep(c1);
    s1_tuser  = mk_user(c1);
    s1_tlast  = (beat_q[1] == len_q[1] - 1);
  endtask

  task automatic advance_src(input bit hs0, input bit hs1);
    bit hs[2];
    hs[0] = hs0;
    hs[1] = hs1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        if (beat_q[i] == len_q[i] - 1) begin
          beat_q[i] = 0;
          pkt_q[i]++;
          left_q[i]--;
        end else begin
          beat_q[i]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    load_src(0, 0);
    drive_src();
    m_tready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #3 ap_rst = 1'b0;
  endtask

  // Run one cycle per exp_q entry, checking m_* and both treadys mid-cycle.
  task automatic run_scn(input string name);
    logic [7:0] e;
    bit rdy, hs0, hs1, on0, on1;
    for (int c = 0; c < exp_q.size(); c++) begin
      rdy = (c < rdy_q.size()) ? rdy_q[c] : 1'b1;
      m_tready = rdy;
      drive_src();
      #1;
      e = exp_q[c];
      on0 = (e != IDLE_CODE) && (e[7:4] == 4'd0);
      on1 = (e != IDLE_CODE) && (e[7:4] == 4'd1);
      chk($sformatf("%s_c%0d_vld", name, c), m_tvalid, e != IDLE_CODE);
      chk($sformatf("%s_c%0d_s0rdy", name, c), s0_tready, on0 & rdy);
      chk($sformatf("%s_c%0d_s1rdy", name, c), s1_tready, on1 & rdy);
      if (e != IDLE_CODE) begin
        chk($sformatf("%s_c%0d_data", name, c), m_tdata, mk_data(e));
        chk($sformatf("%s_c%0d_keep", name, c), m_tkeep, mk_keep(e));
        chk($sformatf("%s_c%0d_user", name, c), m_tuser, mk_user(e));
        chk($sformatf("%s_c%0d_last", name, c), m_tlast, e[1:0] == 2'd1);
      end else begin
        chk($sformatf("%s_c%0d_zdata", name, c), m_tdata, '0);
      end
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      @(posedge ap_clk);
      #1;
      advance_src(hs0, hs1);
    end
  endtask

  task automatic all_ready(input int n);
    rdy_q = {};
    for (int i = 0; i < n; i++) rdy_q.push_back(1'b1);
  endtask

  initial begin
    ap_rst   = 1'b1;
    m_tready = 1'b0;
    load_src(0, 0);
    drive_src();

    // 1: single s0 2-beat packet; tuser of first beat is 48'h62
    do_reset();
    load_src(1, 0);
    drive_src();
    #1;
    chk("t1_rst_vld", m_tvalid, 1'b0);
    chk("t1_rst_s0rdy", s0_tready, 1'b0);
    chk("t1_rst_user", m_tuser, '0);
    chk("t1_rst_state", dbg_state, 1'b0);
    exp_q = {8'hFF, 8'h00, 8'h01, 8'hFF};
    all_ready(exp_q.size());
    run_scn("t1");
    chk("t1_user62", mk_user(8'h00), 48'h62);

    // 2: both sources, two packets each, alternate s0,s1,s0,s1 with one bubble
    do_reset();
    load_src(2, 2);
    exp_q = {8'hFF, 8'h00, 8'h01, 8'hFF, 8'h10, 8'h11, 8'hFF,
             8'h04, 8'h05, 8'hFF, 8'h14, 8'h15, 8'hFF};
    all_ready(exp_q.size());
    run_scn("t2");

    // 3: stall s0 beat 2 for three cycles while s1 waits
    do_reset();
    load_src(1, 1);
    exp_q = {8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h10, 8'h11, 8'hFF};
    all_ready(exp_q.size());
    rdy_q[2] = 1'b0;
    rdy_q[3] = 1'b0;
    rdy_q[4] = 1'b0;
    run_scn("t3");

    // 4: s0 alone, four packets, always re-granted
    load_src(4, 0);
    exp_q = {8'hFF, 8'h00, 8'h01, 8'hFF, 8'h04, 8'h05, 8'hFF,
             8'h08, 8'h09, 8'hFF, 8'h0C, 8'h0D, 8'hFF};
    all_ready(exp_q.size());
    run_scn("t4");
    // last grant was s0, so a tie now goes to s1
    load_src(1, 1);
    exp_q = {8'hFF, 8'h10, 8'h11, 8'hFF, 8'h00, 8'h01, 8'hFF};
    all_ready(exp_q.size());
    run_scn("t4b");

    // 5: reset in the middle of an s1 packet
    do_reset();
    load_src(0, 1);
    drive_src();
    #1;
    chk("t5_idle_vld", m_tvalid, 1'b0);
    @(posedge ap_clk);
    #1;
    chk("t5_busy_vld", m_tvalid, 1'b1);
    chk("t5_busy_s1rdy", s1_tready, 1'b1);
    #1 ap_rst = 1'b1;
    #1;
    chk("t5_rst_vld", m_tvalid, 1'b0);
    chk("t5_rst_s1rdy", s1_tready, 1'b0);
    chk("t5_rst_data", m_tdata, '0);
    chk("t5_rst_keep", m_tkeep, '0);
    chk("t5_rst_user", m_tuser, '0);
    chk("t5_rst_last", m_tlast, 1'b0);
    chk("t5_rst_state", dbg_state, 1'b0);
    @(posedge ap_clk);
    #3 ap_rst = 1'b0;
    load_src(1, 1);
    exp_q = {8'hFF, 8'h00, 8'h01, 8'hFF, 8'h10, 8'h11, 8'hFF};
    all_ready(exp_q.size());
    run_scn("t5");

`ifdef NT_ARB_PKT_CNT_EN
    // 6: counters with CNT_W=2; s1 count of 5 wraps to 1
    do_reset();
    #1;
    chk("t6_rst_cnt0", pkt_cnt0, '0);
    chk("t6_rst_cnt1", pkt_cnt1, '0);
    load_src(3, 5);
    for (int c = 0; c < 30; c++) begin
      bit hs0, hs1;
      m_tready = 1'b1;
      drive_src();
      #1;
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      @(posedge ap_clk);
      #1;
      advance_src(hs0, hs1);
    end
    chk("t6_cnt0", pkt_cnt0, 2'd3);
    chk("t6_cnt1", pkt_cnt1, 2'd1);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
